// File: rtl/bus_dma_arbiter.sv
// bus_dma_arbiter
//
// Shares the single bus_ram port between the cpu_6502 core and a block-copy
// DMA engine. A DMA request drops CPU RDY, waits until the CPU is parked on a
// read cycle, takes the bus, then copies N bytes (read src, write dst). Each
// access is one phi2-aligned bus cycle. After the last byte the bus goes back
// to the CPU.
//
// Ports:
//   i_clk, i_reset           system clock, asynchronous active-high reset
//   i_phi2                   cpu_6502 o_phi2; its falling edge ends a bus cycle
//   i_cpu_addr/data/rw       cpu_6502 bus pins (rw: 1 = read)
//   o_cpu_rdy                to cpu_6502 i_rdy
//   o_cpu_data               read data to cpu_6502
//   o_bus_addr/data/rw       to bus_ram
//   i_bus_data               from bus_ram
//   i_dma_start              one-clock start strobe (ignored unless idle)
//   i_dma_src/dst/len        transfer descriptor, sampled with start
//   o_dma_busy, o_dma_done   busy level / one-clock completion pulse
//
// Build option BUS_DMA_ARBITER_FILL_EN adds i_dma_fill and i_dma_fill_val.
// When fill is set, the read cycles are skipped and every destination byte
// is written with the fill value.

module bus_dma_arbiter #(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_phi2,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [7:0]        i_cpu_data,
    input  logic              i_cpu_rw,
    output logic              o_cpu_rdy,
    output logic [7:0]        o_cpu_data,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [7:0]        o_bus_data,
    output logic              o_bus_rw,
    input  logic [7:0]        i_bus_data,
    input  logic              i_dma_start,
    input  logic [ADDR_W-1:0] i_dma_src,
    input  logic [ADDR_W-1:0] i_dma_dst,
    input  logic [LEN_W-1:0]  i_dma_len,
`ifdef BUS_DMA_ARBITER_FILL_EN
    input  logic              i_dma_fill,
    input  logic [7:0]        i_dma_fill_val,
`endif
    output logic              o_dma_busy,
    output logic              o_dma_done
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        READ,
        WRITE,
        RELEASE
    } state_t;

    state_t            state;
    logic              phi2_q;
    logic              boundary;
    logic              dma_own;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  cnt;
    logic [7:0]        latch;
    logic [7:0]        cpu_hold;
    logic              fill_q;
    logic [7:0]        wr_data;

`ifdef BUS_DMA_ARBITER_FILL_EN
    logic [7:0]        fill_val_q;

    assign wr_data = fill_q ? fill_val_q : latch;
`else
    assign fill_q  = 1'b0;
    assign wr_data = latch;
`endif

    // Falling edge of phi2 seen on this clock: the current bus cycle ends here.
    assign boundary = phi2_q & ~i_phi2;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            phi2_q     <= 1'b0;
            dma_own    <= 1'b0;
            src        <= '0;
            dst        <= '0;
            cnt        <= '0;
            latch      <= '0;
            cpu_hold   <= '0;
            o_cpu_rdy  <= 1'b1;
            o_dma_busy <= 1'b0;
            o_dma_done <= 1'b0;
`ifdef BUS_DMA_ARBITER_FILL_EN
            fill_q     <= 1'b0;
            fill_val_q <= '0;
`endif
        end else begin
            phi2_q     <= i_phi2;
            o_dma_done <= 1'b0;

            // Remember what the CPU last saw, so its data input stays steady
            // while the DMA engine owns the bus.
            if (!dma_own) begin
                cpu_hold <= i_bus_data;
            end

            case (state)
                IDLE: begin
                    if (i_dma_start) begin
                        src <= i_dma_src;
                        dst <= i_dma_dst;
                        cnt <= i_dma_len;
`ifdef BUS_DMA_ARBITER_FILL_EN
                        fill_q     <= i_dma_fill;
                        fill_val_q <= i_dma_fill_val;
`endif
                        if (i_dma_len == '0) begin
                            o_dma_done <= 1'b1;
                        end else begin
                            state      <= HALT;
                            o_cpu_rdy  <= 1'b0;
                            o_dma_busy <= 1'b1;
                        end
                    end
                end

                // A 6502 ignores RDY on write cycles, so the bus is only
                // safe once a cycle ends with the CPU reading.
                HALT: begin
                    if (boundary && i_cpu_rw) begin
                        dma_own <= 1'b1;
                        state   <= fill_q ? WRITE : READ;
                    end
                end

                READ: begin
                    if (boundary) begin
                        latch <= i_bus_data;
                        src   <= src + ADDR_W'(1);
                        state <= WRITE;
                    end
                end

                WRITE: begin
                    if (boundary) begin
                        dst <= dst + ADDR_W'(1);
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            dma_own <= 1'b0;
                            state   <= RELEASE;
                        end else begin
                            state <= fill_q ? WRITE : READ;
                        end
                    end
                end

                RELEASE: begin
                    o_cpu_rdy  <= 1'b1;
                    o_dma_busy <= 1'b0;
                    o_dma_done <= 1'b1;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_bus_addr = i_cpu_addr;
        o_bus_data = i_cpu_data;
        o_bus_rw   = i_cpu_rw;
        o_cpu_data = i_bus_data;
        if (dma_own) begin
            o_cpu_data = cpu_hold;
            o_bus_data = wr_data;
            if (state == WRITE) begin
                o_bus_addr = dst;
                o_bus_rw   = 1'b0;
            end else begin
                o_bus_addr = src;
                o_bus_rw   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// tb_bus_dma_arbiter
//
// Bench for bus_dma_arbiter. It holds a 64 KiB RAM model and a simple
// 6502-like bus master that honours RDY only on read cycles. A phi2 generator
// makes each bus cycle four clocks long. Expected DMA bus cycles are queued
// when a transfer is started and popped as the DMA engine drives the bus.
// Define BUS_DMA_ARBITER_FILL_EN to include the fill transfer.

`timescale 1ns/1ps

module tb_bus_dma_arbiter;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
    } bus_t;

    logic        clk;
    logic        rst;
    logic        phi2;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rw;
    logic [7:0]  bus_rdata;
    logic        dma_start;
    logic [15:0] dma_src;
    logic [15:0] dma_dst;
    logic [7:0]  dma_len;
    logic        dma_busy;
    logic        dma_done;
`ifdef BUS_DMA_ARBITER_FILL_EN
    logic        dma_fill;
    logic [7:0]  dma_fill_val;
`endif

    logic [7:0]  ram [0:65535];
    bus_t        exp_q[$];
    bus_t        cpu_q[$];

    logic        poke_en;
    logic [15:0] poke_a;
    logic [7:0]  poke_d;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned done_cnt;
    int unsigned dma_cycles;
    int unsigned dma_reads;
    int unsigned cpu_writes;
    int unsigned cpu_adv;
    int unsigned rdy_low_clks;
    int unsigned busy_clks;
    logic        rdy_at_bnd;
    logic [7:0]  hold_exp;

    assign bus_rdata = ram[bus_addr];

    bus_dma_arbiter #(
        .LEN_W (8),
        .ADDR_W(16)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_phi2        (phi2),
        .i_cpu_addr    (cpu_addr),
        .i_cpu_data    (cpu_wdata),
        .i_cpu_rw      (cpu_rw),
        .o_cpu_rdy     (cpu_rdy),
        .o_cpu_data    (cpu_rdata),
        .o_bus_addr    (bus_addr),
        .o_bus_data    (bus_wdata),
        .o_bus_rw      (bus_rw),
        .i_bus_data    (bus_rdata),
        .i_dma_start   (dma_start),
        .i_dma_src     (dma_src),
        .i_dma_dst     (dma_dst),
        .i_dma_len     (dma_len),
`ifdef BUS_DMA_ARBITER_FILL_EN
        .i_dma_fill    (dma_fill),
        .i_dma_fill_val(dma_fill_val),
`endif
        .o_dma_busy    (dma_busy),
        .o_dma_done    (dma_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // phi2 generator plus CPU bus master: phi2 is low for two clocks, then high
    // for two. The CPU moves to its next cycle right after each boundary. It
    // stays on a read cycle while RDY was low at that boundary.
    initial begin : cpu_model
        logic [1:0]  ph;
        logic [15:0] pc;
        bus_t        c;
        ph        = 2'd0;
        pc        = 16'h0400;
        phi2      = 1'b0;
        cpu_addr  = 16'h0400;
        cpu_rw    = 1'b1;
        cpu_wdata = 8'h00;
        cpu_adv   = 0;
        forever begin
            @(posedge clk);
            #1;
            ph   = ph + 2'd1;
            phi2 = ph[1];
            if (ph == 2'd1 && (rdy_at_bnd || !cpu_rw)) begin
                if (cpu_q.size() != 0) begin
                    c         = cpu_q.pop_front();
                    cpu_addr  = c.addr;
                    cpu_rw    = c.rw;
                    cpu_wdata = c.data;
                end else begin
                    pc        = {8'h04, pc[7:0] + 8'd1};
                    cpu_addr  = pc;
                    cpu_rw    = 1'b1;
                    cpu_wdata = 8'h00;
                end
                cpu_adv++;
            end
        end
    end

    // RAM model and scoreboard sink. It samples on the falling clock edge
    // before each boundary edge, so all bus signals are stable.
    initial begin : monitor
        logic phi2_prev;
        logic is_dma;
        bus_t e;
        foreach (ram[i]) ram[i] = 8'h00;
        phi2_prev    = 1'b0;
        rdy_at_bnd   = 1'b1;
        hold_exp     = 8'h00;
        done_cnt     = 0;
        dma_cycles   = 0;
        dma_reads    = 0;
        cpu_writes   = 0;
        rdy_low_clks = 0;
        busy_clks    = 0;
        forever begin
            @(negedge clk);
            if (poke_en) ram[poke_a] = poke_d;
            if (dma_done) done_cnt++;
            if (!cpu_rdy) rdy_low_clks++;
            if (dma_busy) busy_clks++;
            if (phi2_prev && !phi2) begin
                rdy_at_bnd = cpu_rdy;
                is_dma = (bus_addr != cpu_addr) || (bus_rw != cpu_rw);
                if (is_dma) begin
                    dma_cycles++;
                    if (bus_rw) dma_reads++;
                    check_eq("cpu_data_hold", cpu_rdata, hold_exp);
                    if (exp_q.size() == 0) begin
                        check_eq("sb_pending", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("sb_addr", bus_addr, e.addr);
                        check_eq("sb_rw", bus_rw, e.rw);
                        if (!e.rw) check_eq("sb_wdata", bus_wdata, e.data);
                    end
                end else if (cpu_rw) begin
                    check_eq("cpu_read_data", cpu_rdata, ram[cpu_addr]);
                end
                if (!bus_rw) begin
                    ram[bus_addr] = bus_wdata;
                    if (!is_dma) cpu_writes++;
                end
                if (!is_dma) hold_exp = ram[bus_addr];
            end
            phi2_prev = phi2;
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_a  = a;
        poke_d  = d;
        poke_en = 1'b1;
        @(negedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic rw, input logic [7:0] d);
        exp_q.push_back('{addr: a, rw: rw, data: d});
    endtask

    task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            push_exp(s + 16'(i), 1'b1, 8'h00);
            push_exp(d + 16'(i), 1'b0, ram[s + 16'(i)]);
        end
    endtask

    task automatic dma_go(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
        dma_src   = s;
        dma_dst   = d;
        dma_len   = n;
        dma_start = 1'b1;
        tick(1);
        dma_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        int unsigned base;
        int unsigned n;
        base = done_cnt;
        n    = 0;
        while (done_cnt == base && n < budget) begin
            tick(1);
            n++;
        end
        check_eq({tag, "_done_pulses"}, done_cnt - base, 1);
    endtask

    initial begin : main
        int unsigned b_dma;
        int unsigned b_rd;
        int unsigned b_done;
        int unsigned b_wr;
        int unsigned b_adv;
        int unsigned b_rdy;
        int unsigned b_busy;
        int unsigned n;
        logic [7:0]  vals [4];

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        poke_en   = 1'b0;
        poke_a    = 16'h0000;
        poke_d    = 8'h00;
        dma_start = 1'b0;
        dma_src   = 16'h0000;
        dma_dst   = 16'h0000;
        dma_len   = 8'h00;
`ifdef BUS_DMA_ARBITER_FILL_EN
        dma_fill     = 1'b0;
        dma_fill_val = 8'h00;
`endif
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        vals[2] = 8'h33;
        vals[3] = 8'h44;

        // Reset state: RDY high, idle, bus transparent to the CPU.
        tick(3);
        check_eq("rst_rdy", cpu_rdy, 1);
        check_eq("rst_busy", dma_busy, 0);
        check_eq("rst_done", dma_done, 0);
        check_eq("rst_bus_addr", bus_addr, cpu_addr);
        check_eq("rst_bus_rw", bus_rw, cpu_rw);
        check_eq("rst_bus_data", bus_wdata, cpu_wdata);
        rst = 1'b0;
        tick(6);

        // Zero-length start: done pulse only, RDY and busy untouched.
        b_done = done_cnt;
        b_rdy  = rdy_low_clks;
        b_busy = busy_clks;
        dma_go(16'h0200, 16'h0300, 8'd0);
        check_eq("len0_done_now", dma_done, 1);
        check_eq("len0_busy_now", dma_busy, 0);
        check_eq("len0_rdy_now", cpu_rdy, 1);
        tick(1);
        check_eq("len0_done_cleared", dma_done, 0);
        tick(20);
        check_eq("len0_rdy_low_clks", rdy_low_clks - b_rdy, 0);
        check_eq("len0_busy_clks", busy_clks - b_busy, 0);
        check_eq("len0_done_pulses", done_cnt - b_done, 1);

        // Four-byte copy 0x0200 -> 0x0300 while the CPU runs at 0x04xx.
        for (int unsigned i = 0; i < 4; i++) begin
            poke(16'h0200 + 16'(i), vals[i]);
            poke(16'h0300 + 16'(i), 8'h00);
        end
        tick(1);
        push_copy(16'h0200, 16'h0300, 4);
        b_dma = dma_cycles;
        dma_go(16'h0200, 16'h0300, 8'd4);
        check_eq("copy_rdy_low", cpu_rdy, 0);
        check_eq("copy_busy", dma_busy, 1);
        wait_done("copy", 400);
        check_eq("copy_rdy_back", cpu_rdy, 1);
        check_eq("copy_busy_clear", dma_busy, 0);
        check_eq("copy_bus_cycles", dma_cycles - b_dma, 8);
        check_eq("copy_sb_empty", exp_q.size(), 0);
        for (int unsigned i = 0; i < 4; i++) begin
            check_eq("copy_ram", ram[16'h0300 + 16'(i)], vals[i]);
        end
        b_adv = cpu_adv;
        tick(16);
        check_eq("copy_cpu_resumes", (cpu_adv > b_adv) ? 1 : 0, 1);

        // Start during a three-write CPU burst: DMA must wait for a read.
        poke(16'h0210, 8'h5A);
        poke(16'h0211, 8'hC3);
        poke(16'h0310, 8'h00);
        poke(16'h0311, 8'h00);
        tick(1);
        cpu_q.push_back('{addr: 16'h01FD, rw: 1'b0, data: 8'h12});
        cpu_q.push_back('{addr: 16'h01FC, rw: 1'b0, data: 8'h34});
        cpu_q.push_back('{addr: 16'h01FB, rw: 1'b0, data: 8'h56});
        n = 0;
        while (cpu_rw && n < 64) begin
            tick(1);
            n++;
        end
        check_eq("burst_write_seen", cpu_rw, 0);
        push_copy(16'h0210, 16'h0310, 2);
        b_dma = dma_cycles;
        b_wr  = cpu_writes;
        dma_go(16'h0210, 16'h0310, 8'd2);
        n = 0;
        while (dma_cycles == b_dma && n < 100) begin
            tick(1);
            n++;
        end
        check_eq("burst_writes_before_dma", cpu_writes - b_wr, 3);
        wait_done("burst", 400);
        check_eq("burst_ram_1fd", ram[16'h01FD], 8'h12);
        check_eq("burst_ram_1fc", ram[16'h01FC], 8'h34);
        check_eq("burst_ram_1fb", ram[16'h01FB], 8'h56);
        check_eq("burst_ram_310", ram[16'h0310], 8'h5A);
        check_eq("burst_ram_311", ram[16'h0311], 8'hC3);
        check_eq("burst_sb_empty", exp_q.size(), 0);
        tick(8);

        // Address wrap on both pointers.
        poke(16'hFFFF, 8'h71);
        poke(16'h0000, 8'h72);
        poke(16'h0001, 8'h73);
        poke(16'h00FE, 8'h00);
        poke(16'h00FF, 8'h00);
        poke(16'h0100, 8'h00);
        tick(1);
        push_exp(16'hFFFF, 1'b1, 8'h00);
        push_exp(16'h00FE, 1'b0, 8'h71);
        push_exp(16'h0000, 1'b1, 8'h00);
        push_exp(16'h00FF, 1'b0, 8'h72);
        push_exp(16'h0001, 1'b1, 8'h00);
        push_exp(16'h0100, 1'b0, 8'h73);
        dma_go(16'hFFFF, 16'h00FE, 8'd3);
        wait_done("wrap", 400);
        check_eq("wrap_sb_empty", exp_q.size(), 0);
        check_eq("wrap_ram_0fe", ram[16'h00FE], 8'h71);
        check_eq("wrap_ram_0ff", ram[16'h00FF], 8'h72);
        check_eq("wrap_ram_100", ram[16'h0100], 8'h73);
        tick(8);

        // Reset while the third byte (dst 0x0302) is being written.
        for (int unsigned i = 0; i < 4; i++) begin
            poke(16'h0300 + 16'(i), 8'hEE);
        end
        tick(1);
        push_copy(16'h0200, 16'h0300, 4);
        dma_go(16'h0200, 16'h0300, 8'd4);
        n = 0;
        while (!(bus_addr == 16'h0302 && !bus_rw) && n < 200) begin
            tick(1);
            n++;
        end
        check_eq("rstmid_reached", {bus_rw, bus_addr}, {1'b0, 16'h0302});
        b_done = done_cnt;
        rst    = 1'b1;
        tick(1);
        check_eq("rstmid_rdy", cpu_rdy, 1);
        check_eq("rstmid_busy", dma_busy, 0);
        check_eq("rstmid_done", dma_done, 0);
        check_eq("rstmid_bus_addr", bus_addr, cpu_addr);
        check_eq("rstmid_bus_rw", bus_rw, cpu_rw);
        rst = 1'b0;
        exp_q.delete();
        tick(20);
        check_eq("rstmid_no_done", done_cnt - b_done, 0);
        check_eq("rstmid_ram_300", ram[16'h0300], 8'h11);
        check_eq("rstmid_ram_301", ram[16'h0301], 8'h22);
        check_eq("rstmid_ram_302", ram[16'h0302], 8'hEE);
        check_eq("rstmid_ram_303", ram[16'h0303], 8'hEE);

`ifdef BUS_DMA_ARBITER_FILL_EN
        // Fill 16 bytes at 0x0500 with 0xA5: writes only, one cycle per byte.
        for (int unsigned i = 0; i < 16; i++) begin
            poke(16'h0500 + 16'(i), 8'h00);
        end
        tick(1);
        for (int unsigned i = 0; i < 16; i++) begin
            push_exp(16'h0500 + 16'(i), 1'b0, 8'hA5);
        end
        b_dma        = dma_cycles;
        b_rd         = dma_reads;
        dma_fill     = 1'b1;
        dma_fill_val = 8'hA5;
        dma_go(16'h0000, 16'h0500, 8'd16);
        dma_fill     = 1'b0;
        wait_done("fill", 600);
        check_eq("fill_bus_cycles", dma_cycles - b_dma, 16);
        check_eq("fill_read_cycles", dma_reads - b_rd, 0);
        check_eq("fill_sb_empty", exp_q.size(), 0);
        for (int unsigned i = 0; i < 16; i++) begin
            check_eq("fill_ram", ram[16'h0500 + 16'(i)], 8'hA5);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_dma_arbiter.md
Name: bus_dma_arbiter

Overview:
- Shares the single bus_ram port between the cpu_6502 core and a block-copy DMA engine.
- On a DMA request it:
  - drops CPU RDY,
  - waits until the CPU is parked on a read cycle,
  - takes the bus and copies N bytes (read src, write dst) in phi2-aligned bus cycles,
  - then hands the bus back.
- Sits between the cpu_6502 bus pins and bus_ram; drives cpu_6502 i_rdy.

Parameters:
- LEN_W, 8, width of transfer length; max transfer = 2^LEN_W-1 bytes.
- ADDR_W, 16, bus address width.

Ports:
- i_clk  input  1  system clock, same clock as cpu_6502 i_clk.
- i_reset  input  1  asynchronous, active-high reset.
- i_phi2  input  1  cpu_6502 o_phi2; its falling edge marks a bus-cycle boundary.
- i_cpu_addr  input  ADDR_W  cpu_6502 o_bus_addr.
- i_cpu_data  input  8  cpu_6502 o_bus_data.
- i_cpu_rw  input  1  cpu_6502 o_rw (1=read).
- o_cpu_rdy  output  1  to cpu_6502 i_rdy.
- o_cpu_data  output  8  read data to cpu_6502 i_bus_data.
- o_bus_addr  output  ADDR_W  to bus_ram i_addr.
- o_bus_data  output  8  to bus_ram i_data.
- o_bus_rw  output  1  to bus_ram i_rw.
- i_bus_data  input  8  bus_ram o_data.
- i_dma_start  input  1  one-clock start strobe.
- i_dma_src  input  ADDR_W  source base address.
- i_dma_dst  input  ADDR_W  destination base address.
- i_dma_len  input  LEN_W  byte count.
- o_dma_busy  output  1  high from accepted start until done.
- o_dma_done  output  1  one-clock pulse at completion.

Behaviour:
- Clock/reset: one clock (i_clk); reset asynchronous, active-high (i_reset).
- Reset values:
  - state=IDLE, o_cpu_rdy=1, o_dma_busy=0, o_dma_done=0;
  - bus owner=CPU, so o_bus_addr/o_bus_data/o_bus_rw follow the CPU inputs;
  - internal regs src/dst/cnt/latch = 0.
- Boundary detect: phi2_q registered each clock; boundary = phi2_q & ~i_phi2.
- Bus ownership changes only on a boundary clock.
- CPU owner:
  - bus outputs = CPU inputs, combinational;
  - o_cpu_data = i_bus_data.
- DMA owner:
  - o_cpu_data holds the last CPU-owned value;
  - bus outputs come from DMA regs.
- States:
  - IDLE:
    - On i_dma_start: latch src/dst/len.
    - len==0: stay IDLE, o_dma_done pulses next clock, busy never rises, RDY untouched.
    - Else: -> HALT, o_cpu_rdy=0 and o_dma_busy=1 next clock.
    - i_dma_start outside IDLE is ignored.
  - HALT:
    - At each boundary, sample i_cpu_rw.
    - rw==1 (CPU stalled on a read): take bus -> READ.
    - rw==0 (6502 writes ignore RDY; up to 3 in a row): stay HALT.
  - READ:
    - Bus cycle: o_bus_addr=src, o_bus_rw=1.
    - At boundary: latch i_bus_data, src<=src+1 (mod 2^ADDR_W) -> WRITE.
  - WRITE:
    - Bus cycle: o_bus_addr=dst, o_bus_data=latch, o_bus_rw=0.
    - At boundary: dst<=dst+1 (mod 2^ADDR_W), cnt<=cnt-1.
    - cnt==1 before decrement: -> RELEASE, bus returned to CPU at this same boundary. Otherwise -> READ.
  - RELEASE:
    - Next clock: o_cpu_rdy=1, o_dma_busy=0, o_dma_done=1 for one clock -> IDLE.
- Throughput: 2 bus cycles per byte. Latency from start to first DMA bus cycle = 1 to 4 bus cycles (halt wait).
- Address wrap: src/dst wrap 0xFFFF -> 0x0000 silently.
- Simultaneous start and reset: reset wins.
- Reset mid-transfer:
  - immediate return to IDLE, RDY=1, bus to CPU;
  - bytes already written stay written; no done pulse.
- i_phi2 stuck: state holds, no timeout.

Optional Feature:
- Macro: BUS_DMA_ARBITER_FILL_EN.
- Enabled:
  - Adds ports i_dma_fill (1) and i_dma_fill_val (8), sampled with start.
  - When fill=1, READ is skipped: HALT -> WRITE, each byte writes fill_val, src is unused.
  - Cost is 1 bus cycle per byte.
- Disabled:
  - Ports absent; copy-only behaviour as above.

Test Plan:
- Reset asserted mid-WRITE at byte 2 of len=4 -> next clock o_cpu_rdy=1, busy=0, bus follows CPU, no done pulse, 0x0300/0x0301 written and 0x0302/0x0303 unchanged.
- CPU running functional test at 0x0400; start src=0x0200, dst=0x0300, len=4 with RAM[0x200..0x203]=11,22,33,44 -> RAM[0x300..0x303]=11,22,33,44, exactly 8 DMA bus cycles, one done pulse, CPU resumes and test still passes.
- Start while CPU is in a BRK/JSR write burst (rw=0 for 3 cycles) -> first DMA read occurs only after the boundary where rw==1; no CPU write is lost.
- len=0 start -> done pulse after 1 clock, o_cpu_rdy never drops, busy stays 0.
- src=0xFFFF, dst=0x00FE, len=3 -> reads 0xFFFF, 0x0000, 0x0001; writes 0x00FE, 0x00FF, 0x0100.
- FILL_EN build: fill=1, val=0xA5, dst=0x0500, len=16 -> RAM[0x500..0x50F]=0xA5, 16 DMA bus cycles, zero read cycles.
